ospfb_pwr_acc: RTL and testbench
================================

OSPFB_PWR_ACC -- requirements
Module: ospfb_pwr_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed bits per re/im component of the input sample.
REQ-002 SHALL have parameter FFT_LEN, default 64, channels per frame (power of two, 2..256).
REQ-003 SHALL have parameter ACC_LEN, default 16, frames summed per integration (>=1).
REQ-004 SHALL have parameter OUT_WID, default 48, accumulator/output width (>= 2*WIDTH+1; elaboration error otherwise).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 s_axis  axis slave  2*WIDTH  tdata = {im, re}, tvalid, tready; OSPFB FFT output stream.
REQ-008 s_axis_tlast  input  1  end of frame marker from OSPFB.
REQ-009 m_axis  axis master  OUT_WID  tdata = integrated power, tvalid, tready.
REQ-010 m_axis_tlast  output  1  high on channel FFT_LEN-1 of a dump.
REQ-011 m_axis_tuser  output  8  channel index of current output beat (zero-extended).
REQ-012 event_tlast_err  output  1  one-cycle pulse on tlast/channel mismatch.
REQ-013 acc_ovf  output  1  one-cycle pulse on accumulator overflow (see Configuration).

Function
REQ-014 Per accepted beat SHALL compute pwr = re*re + im*im, unsigned, 2*WIDTH+1 bits, exact.
REQ-015 SHALL keep a channel counter 0..FFT_LEN-1 (advances per accepted beat, wraps) and a frame counter 0..ACC_LEN-1 (advances on the beat with channel FFT_LEN-1).
REQ-016 SHALL hold per-channel accumulators in an FFT_LEN-deep memory, read-modify-write per beat.
REQ-017 Frame 0 of an integration SHALL write pwr (not add), so memory contents need no clearing.
REQ-018 State ACC (frame < ACC_LEN-1): write acc+pwr back; no output beat produced.
REQ-019 State DUMP (frame = ACC_LEN-1): emit acc+pwr on m_axis with tuser = channel, tlast at FFT_LEN-1; no write-back; ACC_LEN=1 means every frame is DUMP.
REQ-020 Transitions: ACC->DUMP after last channel of frame ACC_LEN-2; DUMP->ACC (frame 0) after last channel of dump frame.
REQ-021 Latency SHALL be 2 cycles from s_axis acceptance to m_axis tvalid with no stall.
REQ-022 s_axis.tready SHALL equal !(m_axis.tvalid && !m_axis.tready); whole pipeline holds while stalled; no beat lost or duplicated.
REQ-023 m_axis tdata/tlast/tuser SHALL be stable while tvalid && !tready.
REQ-024 Back-to-back read-modify-write of the same channel SHALL not occur for FFT_LEN>=2; for FFT_LEN=2, forwarding SHALL keep sums exact.
REQ-025 s_axis_tlast at channel != FFT_LEN-1, or missing at FFT_LEN-1: pulse event_tlast_err, set channel and frame counters to 0 after that beat, abandon current integration (no partial dump output).
REQ-026 Beats already in the pipeline at a resync SHALL still complete normally.

Reset
REQ-027 While rst_n low: m_axis.tvalid=0, tdata=0, tlast=0, tuser=0, event_tlast_err=0, acc_ovf=0, s_axis.tready=0, counters=0, state=ACC.
REQ-028 Reset assertion mid-integration or mid-dump SHALL discard all pipeline contents immediately; after release tready=1 on first clock and integration restarts at frame 0, channel 0.

Configuration
REQ-029 Macro PWR_ACC_SAT_EN defined: sums exceeding 2^OUT_WID-1 SHALL clamp to 2^OUT_WID-1 and pulse acc_ovf on that beat.
REQ-030 Macro PWR_ACC_SAT_EN undefined: sums SHALL wrap modulo 2^OUT_WID and acc_ovf SHALL be tied 0.

Verification (WIDTH=16, FFT_LEN=64, ACC_LEN=4, OUT_WID=48 unless stated)
REQ-031 re=3, im=4 every beat, 4 frames, m_tready=1 -> 64 outputs of 100, tuser 0..63, tlast only on tuser=63, first tvalid 2 cycles after first dump-frame beat.
REQ-032 Same stimulus, m_tready random 50% during dump -> identical 64 values in order; s_tready low exactly on stalled cycles.
REQ-033 tlast on channel 10 of frame 1 -> one event_tlast_err pulse, no output for that integration, next 4 clean frames of value 7 (re=7, im=0) output 196 per channel.
REQ-034 OUT_WID=33, re=im=-32768, 4 frames -> with PWR_ACC_SAT_EN: outputs 2^33-1, acc_ovf pulses; without: outputs 0, acc_ovf stays 0.
REQ-035 rst_n low at dump channel 20 -> outputs zeroed same cycle; after release 4 new frames of re=1, im=1 -> 64 outputs of 8.
REQ-036 ACC_LEN=1, ramp re=channel, im=0 -> output channel k = k*k, 2-cycle latency, tlast every 64th beat.

Source files
------------

// File: rtl/ospfb_pwr_acc.sv
// ospfb_pwr_acc: integrates the power spectrum of an OSPFB FFT output stream.
//
// Each accepted beat {im, re} is turned into pwr = re*re + im*im and summed
// per channel over ACC_LEN frames. The sums live in an FFT_LEN-deep memory.
// The final frame of an integration is the dump frame. During that frame each
// completed sum goes out on m_axis and is not written back. Frame 0 overwrites
// the memory, so the memory never has to be cleared.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axis_tdata          {im, re}, each a signed WIDTH-bit value
//   s_axis_tvalid/tready  input handshake; tready drops only under output back-pressure
//   s_axis_tlast          end-of-frame marker, expected on channel FFT_LEN-1
//   m_axis_tdata          integrated power, OUT_WID bits
//   m_axis_tvalid/tready  output handshake
//   m_axis_tlast          high on channel FFT_LEN-1 of a dump
//   m_axis_tuser          channel index of the current output beat
//   event_tlast_err       one-cycle pulse when tlast disagrees with the channel counter
//   acc_ovf               one-cycle pulse when a saturating sum clamps
//
// Build option
//   PWR_ACC_SAT_EN  when defined, sums clamp at 2^OUT_WID-1 and acc_ovf pulses.
//                   When undefined, sums wrap modulo 2^OUT_WID and acc_ovf is 0.

module ospfb_pwr_acc #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned FFT_LEN = 64,
  parameter int unsigned ACC_LEN = 16,
  parameter int unsigned OUT_WID = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*WIDTH-1:0]   s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [OUT_WID-1:0]   m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [7:0]           m_axis_tuser,
  output logic                 event_tlast_err,
  output logic                 acc_ovf
);

  localparam int unsigned PwrW = 2 * WIDTH + 1;
  localparam int unsigned ChW  = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
  localparam int unsigned FrmW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  localparam logic [ChW-1:0]  LastCh     = ChW'(FFT_LEN - 1);
  localparam logic [FrmW-1:0] LastFrm    = FrmW'(ACC_LEN - 1);
  // Only meaningful for ACC_LEN > 1; that use is guarded below.
  localparam logic [FrmW-1:0] PreDumpFrm = FrmW'(ACC_LEN - 2);

  // Elaboration-time parameter checks.
  if (OUT_WID < PwrW) begin : g_bad_out_wid
    $error("ospfb_pwr_acc: OUT_WID must be at least 2*WIDTH+1");
  end
  if (FFT_LEN < 2 || FFT_LEN > 256 || (FFT_LEN & (FFT_LEN - 1)) != 0) begin : g_bad_fft_len
    $error("ospfb_pwr_acc: FFT_LEN must be a power of two in 2..256");
  end
  if (ACC_LEN < 1) begin : g_bad_acc_len
    $error("ospfb_pwr_acc: ACC_LEN must be at least 1");
  end

  typedef enum logic [0:0] {StAcc, StDump} state_e;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic m_valid_q;
  logic advance;  // the whole pipeline moves one step this cycle
  logic accept;

  assign advance       = !m_valid_q || m_axis_tready;
  assign s_axis_tready = rst_n && advance;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // ---------------------------------------------------------------------------
  // Channel / frame counters and ACC/DUMP FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [ChW-1:0]  ch_q, ch_d;
  logic [FrmW-1:0] frm_q, frm_d;
  logic            last_ch;
  logic            tlast_err;
  logic            beat_dump;
  logic            beat_first;

  assign last_ch   = (ch_q == LastCh);
  assign tlast_err = (s_axis_tlast != last_ch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAcc;
      ch_q    <= '0;
      frm_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      frm_q   <= frm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (tlast_err) begin
        state_d = StAcc;
      end else if (last_ch) begin
        case (state_q)
          StAcc:   if (ACC_LEN > 1 && frm_q == PreDumpFrm) state_d = StDump;
          StDump:  state_d = StAcc;
          default: state_d = StAcc;
        endcase
      end
    end
  end

  always_comb begin
    ch_d  = ch_q;
    frm_d = frm_q;
    if (accept) begin
      if (tlast_err) begin
        // Resync: the next beat starts a fresh integration.
        ch_d  = '0;
        frm_d = '0;
      end else if (last_ch) begin
        ch_d  = '0;
        frm_d = (frm_q == LastFrm) ? '0 : frm_q + FrmW'(1);
      end else begin
        ch_d  = ch_q + ChW'(1);
      end
    end
  end

  // With ACC_LEN = 1 the FSM never leaves StAcc, yet every frame is a dump.
  always_comb begin
    beat_dump  = (ACC_LEN == 1) || (state_q == StDump);
    beat_first = (frm_q == '0);
  end

  // ---------------------------------------------------------------------------
  // Stage A: captured input beat
  // ---------------------------------------------------------------------------
  logic                    a_valid_q;
  logic signed [WIDTH-1:0] a_re_q, a_im_q;
  logic [ChW-1:0]          a_ch_q;
  logic                    a_first_q;
  logic                    a_dump_q;
  logic                    err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_re_q    <= '0;
      a_im_q    <= '0;
      a_ch_q    <= '0;
      a_first_q <= 1'b0;
      a_dump_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= accept && tlast_err;
      if (advance) begin
        a_valid_q <= accept;
        if (accept) begin
          a_re_q    <= signed'(s_axis_tdata[WIDTH-1:0]);
          a_im_q    <= signed'(s_axis_tdata[2*WIDTH-1:WIDTH]);
          a_ch_q    <= ch_q;
          a_first_q <= beat_first;
          a_dump_q  <= beat_dump;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Power, accumulate, saturate/wrap
  // ---------------------------------------------------------------------------
  logic signed [2*WIDTH-1:0] re_sq, im_sq;
  logic [PwrW-1:0]           pwr;
  logic [OUT_WID-1:0]        acc_base;
  logic [OUT_WID:0]          sum_ext;
  logic [OUT_WID-1:0]        sum;
  logic                      ovf_hit;
  logic [OUT_WID-1:0]        mem_q [FFT_LEN];

  always_comb begin
    re_sq = a_re_q * a_re_q;
    im_sq = a_im_q * a_im_q;
    // Both squares are non-negative, so zero-extending is exact.
    pwr   = {1'b0, re_sq} + {1'b0, im_sq};
    // The memory is written on the same edge that moves a beat out of stage A.
    // Stage A therefore always reads the sum of every earlier beat, and no
    // forwarding path is needed, even when FFT_LEN = 2.
    acc_base = a_first_q ? '0 : mem_q[a_ch_q];
    sum_ext  = {1'b0, acc_base} + (OUT_WID + 1)'(pwr);
`ifdef PWR_ACC_SAT_EN
    ovf_hit = sum_ext[OUT_WID];
    sum     = ovf_hit ? '1 : sum_ext[OUT_WID-1:0];
`else
    ovf_hit = 1'b0;
    sum     = sum_ext[OUT_WID-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (advance && a_valid_q && !a_dump_q) begin
      mem_q[a_ch_q] <= sum;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage B: output register
  // ---------------------------------------------------------------------------
  logic [OUT_WID-1:0] m_data_q;
  logic               m_last_q;
  logic [7:0]         m_user_q;
  logic               ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_user_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_q <= advance && a_valid_q && ovf_hit;
      if (advance) begin
        m_valid_q <= a_valid_q && a_dump_q;
        if (a_valid_q && a_dump_q) begin
          m_data_q <= sum;
          m_last_q <= (a_ch_q == LastCh);
          m_user_q <= 8'(a_ch_q);
        end
      end
    end
  end

  assign m_axis_tvalid   = m_valid_q;
  assign m_axis_tdata    = m_data_q;
  assign m_axis_tlast    = m_last_q;
  assign m_axis_tuser    = m_user_q;
  assign event_tlast_err = err_q;
  assign acc_ovf         = ovf_q;

endmodule

// File: tb/tb_ospfb_pwr_acc.sv
// Bench for ospfb_pwr_acc. Three instances share one input stream, selected by
// sel: dut0 (ACC_LEN=4, OUT_WID=48), dut1 (OUT_WID=33) and dut2 (ACC_LEN=1).
// A reference model pushes the expected dump beats into per-instance queues.
// A monitor pops an entry and compares it on every output handshake.

module tb_ospfb_pwr_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic signed [15:0] s_re, s_im;
  logic               s_last, s_valid;
  int                 sel;
  logic [31:0]        s_data;
  logic [2:0]         s_vld, s_rdy, m_vld, m_rdy, m_lst, err, ovf;
  logic [47:0]        d0, d2;
  logic [32:0]        d1;
  logic [7:0]         u0, u1, u2;

  assign s_data = {s_im, s_re};
  assign s_vld  = {s_valid && sel == 2, s_valid && sel == 1, s_valid && sel == 0};

  ospfb_pwr_acc #(.WIDTH(16), .FFT_LEN(64), .ACC_LEN(4), .OUT_WID(48)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(s_vld[0]),
    .s_axis_tready(s_rdy[0]), .s_axis_tlast(s_last), .m_axis_tdata(d0),
    .m_axis_tvalid(m_vld[0]), .m_axis_tready(m_rdy[0]), .m_axis_tlast(m_lst[0]),
    .m_axis_tuser(u0), .event_tlast_err(err[0]), .acc_ovf(ovf[0]));

  ospfb_pwr_acc #(.WIDTH(16), .FFT_LEN(64), .ACC_LEN(4), .OUT_WID(33)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(s_vld[1]),
    .s_axis_tready(s_rdy[1]), .s_axis_tlast(s_last), .m_axis_tdata(d1),
    .m_axis_tvalid(m_vld[1]), .m_axis_tready(m_rdy[1]), .m_axis_tlast(m_lst[1]),
    .m_axis_tuser(u1), .event_tlast_err(err[1]), .acc_ovf(ovf[1]));

  ospfb_pwr_acc #(.WIDTH(16), .FFT_LEN(64), .ACC_LEN(1), .OUT_WID(48)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(s_vld[2]),
    .s_axis_tready(s_rdy[2]), .s_axis_tlast(s_last), .m_axis_tdata(d2),
    .m_axis_tvalid(m_vld[2]), .m_axis_tready(m_rdy[2]), .m_axis_tlast(m_lst[2]),
    .m_axis_tuser(u2), .event_tlast_err(err[2]), .acc_ovf(ovf[2]));

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: exact per-channel sums, clamped or wrapped on output
  // ---------------------------------------------------------------------------
  typedef struct {
    longint unsigned data;
    int              user;
    bit              last;
    int              cyc;  // expected output cycle, or -1 when not checked
  } exp_t;

  exp_t            q0[$], q1[$], q2[$];
  int              acc_len[3] = '{4, 4, 1};
  int              owid[3]    = '{48, 33, 48};
  int              m_ch[3], m_frm[3];
  longint unsigned m_sum[3][64];
  int              exp_err[3], exp_ovf[3];
  int              got_err[3], got_ovf[3];
  bit              stall_en, lat_chk;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ch[k]  = 0;
      m_frm[k] = 0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic model_beat(input int k, input int re, input int im, input bit last,
                            input int drive_cyc);
    longint unsigned p, maxv, v;
    exp_t            e;
    int              ch;
    ch   = m_ch[k];
    p    = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    maxv = (64'd1 << owid[k]) - 64'd1;
    if (m_frm[k] == 0) m_sum[k][ch] = p;
    else m_sum[k][ch] = m_sum[k][ch] + p;
`ifdef PWR_ACC_SAT_EN
    if (m_sum[k][ch] > maxv) exp_ovf[k]++;
    v = (m_sum[k][ch] > maxv) ? maxv : m_sum[k][ch];
`else
    v = m_sum[k][ch] & maxv;
`endif
    if (m_frm[k] == acc_len[k] - 1) begin
      e.data = v;
      e.user = ch;
      e.last = (ch == 63);
      e.cyc  = lat_chk ? drive_cyc + 2 : -1;
      case (k)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    if (last != (ch == 63)) begin
      exp_err[k]++;
      m_ch[k]  = 0;
      m_frm[k] = 0;
    end else if (ch == 63) begin
      m_ch[k]  = 0;
      m_frm[k] = (m_frm[k] + 1) % acc_len[k];
    end else begin
      m_ch[k] = ch + 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: samples 2 time units after the falling edge
  // ---------------------------------------------------------------------------
  int              viol_rdy = 0, viol_stable = 0;
  logic [2:0]      prev_stall = '0;
  longint unsigned prev_dat[3];
  int              prev_usr[3];
  logic [2:0]      prev_lst;

  task automatic pop_check(input int k, input longint unsigned d, input int u, input bit l);
    exp_t e;
    bit   have = 1'b0;
    case (k)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_chk++;
      $display("FAIL unexpected_beat dut%0d: got data %0d, expected no beat", k, d);
      return;
    end
    check($sformatf("data dut%0d ch%0d", k, e.user), d, e.data);
    check($sformatf("tuser dut%0d", k), longint'(u), longint'(e.user));
    check($sformatf("tlast dut%0d ch%0d", k, e.user), longint'(l), longint'(e.last));
    if (e.cyc >= 0) check($sformatf("latency dut%0d ch%0d", k, e.user), cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    longint unsigned d;
    int              u;
    #2;
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? longint'(d0) : (k == 1) ? longint'(d1) : longint'(d2);
      u = (k == 0) ? int'(u0) : (k == 1) ? int'(u1) : int'(u2);
      if (s_rdy[k] !== (rst_n && !(m_vld[k] && !m_rdy[k]))) viol_rdy++;
      if (prev_stall[k] && (!m_vld[k] || d != prev_dat[k] || u != prev_usr[k] ||
                            m_lst[k] != prev_lst[k])) viol_stable++;
      if (err[k]) got_err[k]++;
      if (ovf[k]) got_ovf[k]++;
      if (m_vld[k] && m_rdy[k]) pop_check(k, d, u, m_lst[k]);
      prev_stall[k] = m_vld[k] && !m_rdy[k];
      prev_dat[k]   = d;
      prev_usr[k]   = u;
      prev_lst[k]   = m_lst[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic set_ready();
    for (int j = 0; j < 3; j++) m_rdy[j] = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send(input int k, input int re, input int im, input bit last);
    bit done = 1'b0;
    int tries = 0;
    while (!done) begin
      @(negedge clk);
      set_ready();
      sel = k;
      s_re = 16'(re);
      s_im = 16'(im);
      s_last = last;
      s_valid = 1'b1;
      #1;
      if (s_rdy[k]) begin
        model_beat(k, re, im, last, cyc);
        done = 1'b1;
      end else if (++tries > 1000) begin
        n_chk++;
        $display("FAIL accept_timeout dut%0d: beat not accepted in 1000 cycles", k);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      set_ready();
    end
  endtask

  task automatic send_const_frames(input int k, input int nfrm, input int re, input int im);
    for (int f = 0; f < nfrm; f++)
      for (int c = 0; c < 64; c++) send(k, re, im, c == 63);
  endtask

  task automatic drain();
    int n = 0;
    stall_en = 1'b0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && n < 300) begin
      idle(1);
      n++;
    end
    idle(4);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    check("drain_q2", q2.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, m_vld, 0);
    check({tag, "_tready"}, s_rdy, 0);
    check({tag, "_tdata0"}, d0, 0);
    check({tag, "_tdata1"}, d1, 0);
    check({tag, "_tuser0"}, u0, 0);
    check({tag, "_tlast"}, m_lst, 0);
    check({tag, "_err_ovf"}, {err, ovf}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_re = '0;
    s_im = '0;
    sel = 0;
    m_rdy = 3'b111;
    stall_en = 1'b0;
    lat_chk = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_err[k] = 0;
      exp_ovf[k] = 0;
      got_err[k] = 0;
      got_ovf[k] = 0;
    end
    model_reset();

    // Reset state, then release; tready must come up immediately.
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("tready_after_release", s_rdy, 3'b111);

    // 4 frames of re=3, im=4 with no back-pressure: 64 x 100 and 2-cycle latency.
    lat_chk = 1'b1;
    send_const_frames(0, 4, 3, 4);
    lat_chk = 1'b0;
    idle(4);

    // Same stimulus with random back-pressure.
    stall_en = 1'b1;
    send_const_frames(0, 4, 3, 4);
    drain();

    // A tlast on channel 10 of frame 1 abandons the integration. Then 4 clean
    // frames of re=7, im=0 give 196 per channel.
    send_const_frames(0, 1, 3, 4);
    for (int c = 0; c <= 10; c++) send(0, 3, 4, c == 10);
    send_const_frames(0, 4, 7, 0);
    drain();

    // Random data with random back-pressure, two full integrations.
    stall_en = 1'b1;
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 64; c++)
        send(0, $signed(16'($urandom())), $signed(16'($urandom())), c == 63);
    drain();

    // OUT_WID=33, re=im=-32768: 4 * 2^31 = 2^33 clamps or wraps to 0.
    send_const_frames(1, 4, -32768, -32768);
    drain();

    // ACC_LEN=1 ramp: output k*k, tlast every 64th beat, 2-cycle latency.
    lat_chk = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 64; c++) send(2, c, 0, c == 63);
    lat_chk = 1'b0;
    drain();

    // Reset during the dump at channel 20. Then restart with re=im=1, giving 8.
    send_const_frames(0, 3, 5, 5);
    for (int c = 0; c <= 20; c++) send(0, 5, 5, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("tready_after_midreset", s_rdy, 3'b111);
    send_const_frames(0, 4, 1, 1);
    drain();

    // Event counts and protocol invariants.
    check("tlast_err_pulses_dut0", got_err[0], exp_err[0]);
    check("tlast_err_pulses_dut1", got_err[1], exp_err[1]);
    check("acc_ovf_pulses_dut0", got_ovf[0], exp_ovf[0]);
    check("acc_ovf_pulses_dut1", got_ovf[1], exp_ovf[1]);
    check("tready_vs_stall_violations", viol_rdy, 0);
    check("stall_stability_violations", viol_stable, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
